// File: rtl/text_pkg.sv
// Shared types and constants for the text-mode writer: op codes, FSM encoding,
// screen geometry defaults, message IDs and the cell address helper.
package text_pkg;

   localparam int unsigned COLS_DEF = 80;
   localparam int unsigned ROWS_DEF = 30;

   typedef enum logic [1:0] {
      OP_WCHAR = 2'd0,
      OP_CLEAR = 2'd1,
      OP_MSG   = 2'd2,
      OP_NOP   = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WCHAR,
      ST_CLEAR,
      ST_MSG,
      ST_FIN
   } state_e;

   localparam logic [2:0] MSG_TITLE = 3'd0;
   localparam logic [2:0] MSG_WIN   = 3'd1;
   localparam logic [2:0] MSG_OVER  = 3'd2;
   localparam logic [2:0] MSG_SCORE = 3'd3;

   // Linear cell index; full 32-bit product before the 12-bit cut.
   function automatic logic [11:0] cell_addr(input logic [5:0] row, input logic [6:0] col,
                                             input int unsigned cols);
      return 12'(32'(row) * cols + 32'(col));
   endfunction

endpackage

// File: rtl/text_screen_writer_if.sv
// Command port of the text screen writer: valid/ready command fields plus
// busy/done/err status.
interface text_screen_writer_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [4:0] cmd_row;
   logic [6:0] cmd_col;
   logic [6:0] cmd_char;
   logic [2:0] cmd_msg_id;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_char, cmd_msg_id,
      input  cmd_ready, busy, done, err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_char, cmd_msg_id,
      output cmd_ready, busy, done, err
   );
endinterface

// File: rtl/msg_rom.sv
// Canned message table: combinational (id, index) -> ASCII code, plus length.
// Strings are left-justified in a 16-byte field so index 0 is the top byte.
module msg_rom
   import text_pkg::*;
(
   input  logic [2:0] i_id,
   input  logic [3:0] i_idx,
   output logic [6:0] o_char,
   output logic [3:0] o_len
);

   localparam logic [127:0] STR_TITLE = {"WHACK A MOLE", 32'h0};
   localparam logic [127:0] STR_WIN   = {"GAME WIN", 64'h0};
   localparam logic [127:0] STR_OVER  = {"GAME OVER", 56'h0};
   localparam logic [127:0] STR_SCORE = {"SCORE:", 80'h0};

   logic [127:0] w_str;
   logic [3:0]   w_ridx;

   always_comb begin
      w_str = '0;
      o_len = '0;
      case (i_id)
         MSG_TITLE: begin w_str = STR_TITLE; o_len = 4'd12; end
         MSG_WIN:   begin w_str = STR_WIN;   o_len = 4'd8;  end
         MSG_OVER:  begin w_str = STR_OVER;  o_len = 4'd9;  end
         MSG_SCORE: begin w_str = STR_SCORE; o_len = 4'd6;  end
         default:   ;
      endcase
   end

   assign w_ridx = 4'd15 - i_idx;
   assign o_char = w_str[{w_ridx, 3'b000} +: 7];

endmodule

// File: rtl/text_screen_writer.sv
// Character-cell RAM with a command-driven writer FSM (char / clear / message)
// and a registered pixel-addressed read port for the glyph renderer.
module text_screen_writer
   import text_pkg::*;
#(
   parameter int unsigned COLS      = COLS_DEF,
   parameter int unsigned ROWS      = ROWS_DEF,
   parameter logic [6:0]  FILL_CHAR = 7'h20
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   text_screen_writer_if.slave  cmd,
   input  logic [9:0]           i_x,
   input  logic [9:0]           i_y,
   output logic [6:0]           o_ascii_out
);

   localparam int unsigned CELLS = COLS * ROWS;

   state_e      r_state, w_state_nxt;
   logic [4:0]  r_row, w_row_nxt;
   logic [6:0]  r_col, w_col_nxt;
   logic [6:0]  r_char, w_char_nxt;
   logic [2:0]  r_id, w_id_nxt;
   logic [3:0]  r_idx, w_idx_nxt;
   logic [11:0] r_cnt, w_cnt_nxt;
   logic        r_err, w_err_nxt;
   logic [6:0]  r_ascii;

   logic        w_we;
   logic [11:0] w_waddr;
   logic [6:0]  w_wdata;
   logic        w_cmd_in;
   logic [2:0]  w_rom_id;
   logic [6:0]  w_rom_char;
   logic [3:0]  w_rom_len;

   logic [6:0]  r_mem [CELLS];

   // In IDLE the ROM looks up the incoming id so length is known at acceptance.
   assign w_rom_id = (r_state == ST_IDLE) ? cmd.cmd_msg_id : r_id;

   msg_rom u_msg_rom (
      .i_id   (w_rom_id),
      .i_idx  (r_idx),
      .o_char (w_rom_char),
      .o_len  (w_rom_len)
   );

   assign w_cmd_in = (32'(cmd.cmd_row) < ROWS) && (32'(cmd.cmd_col) < COLS);

   always_comb begin
      w_state_nxt = r_state;
      w_row_nxt   = r_row;
      w_col_nxt   = r_col;
      w_char_nxt  = r_char;
      w_id_nxt    = r_id;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_err_nxt   = r_err;
      w_we        = 1'b0;
      w_waddr     = cell_addr({1'b0, r_row}, r_col, COLS);
      w_wdata     = r_char;
      case (r_state)
         ST_IDLE: begin
            if (cmd.cmd_valid) begin
               w_row_nxt  = cmd.cmd_row;
               w_col_nxt  = cmd.cmd_col;
               w_char_nxt = cmd.cmd_char;
               w_id_nxt   = cmd.cmd_msg_id;
               w_idx_nxt  = '0;
               w_cnt_nxt  = '0;
               w_err_nxt  = 1'b0;
               if (cmd.cmd_op == OP_CLEAR) begin
                  w_state_nxt = ST_CLEAR;
               end else if (cmd.cmd_op == OP_NOP) begin
                  w_state_nxt = ST_FIN;
               end else if (!w_cmd_in) begin
                  w_state_nxt = ST_FIN;
                  w_err_nxt   = 1'b1;
               end else if (cmd.cmd_op == OP_WCHAR) begin
                  w_state_nxt = ST_WCHAR;
               end else if (w_rom_len == 4'd0) begin
                  w_state_nxt = ST_FIN;
               end else begin
                  w_state_nxt = ST_MSG;
               end
            end
         end
         ST_WCHAR: begin
            w_we        = 1'b1;
            w_state_nxt = ST_FIN;
         end
         ST_CLEAR: begin
            w_we    = 1'b1;
            w_waddr = r_cnt;
            w_wdata = FILL_CHAR;
            if (32'(r_cnt) == CELLS - 1) w_state_nxt = ST_FIN;
            else                         w_cnt_nxt   = r_cnt + 12'd1;
         end
         ST_MSG: begin
            w_we    = 1'b1;
            w_wdata = w_rom_char;
            // Cursor runs row-major and wraps bottom-right back to top-left.
            if (32'(r_col) == COLS - 1) begin
               w_col_nxt = '0;
               w_row_nxt = (32'(r_row) == ROWS - 1) ? 5'd0 : r_row + 5'd1;
            end else begin
               w_col_nxt = r_col + 7'd1;
            end
            if (r_idx == w_rom_len - 4'd1) w_state_nxt = ST_FIN;
            else                           w_idx_nxt   = r_idx + 4'd1;
         end
         ST_FIN:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= ST_IDLE;
         r_row   <= '0;
         r_col   <= '0;
         r_char  <= '0;
         r_id    <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_row   <= w_row_nxt;
         r_col   <= w_col_nxt;
         r_char  <= w_char_nxt;
         r_id    <= w_id_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_err   <= w_err_nxt;
      end
   end

   assign cmd.cmd_ready = (r_state == ST_IDLE);
   assign cmd.busy      = (r_state != ST_IDLE);
   assign cmd.done      = (r_state == ST_FIN);
   assign cmd.err       = (r_state == ST_FIN) && r_err;

   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   logic [6:0]  w_rcol;
   logic [5:0]  w_rrow;
   logic        w_rd_in;
   logic [11:0] w_raddr;
   logic        w_unused_sub;

   assign w_rcol       = i_x[9:3];
   assign w_rrow       = i_y[9:4];
   assign w_unused_sub = ^{i_x[2:0], i_y[3:0]};
   assign w_rd_in      = (32'(w_rcol) < COLS) && (32'(w_rrow) < ROWS);
   assign w_raddr      = cell_addr(w_rrow, w_rcol, COLS);

   // Non-blocking read alongside the write gives read-first behaviour.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)     r_ascii <= FILL_CHAR;
      else if (w_rd_in) r_ascii <= r_mem[w_raddr];
      else              r_ascii <= FILL_CHAR;
   end

   assign o_ascii_out = r_ascii;

endmodule

// File: tb/tb_text_screen_writer.sv
// Directed bench for text_screen_writer: command latencies, error pulses,
// message wrap-around, read-port addressing and reset abort mid-clear.
module tb_text_screen_writer;
   import text_pkg::*;

   logic       clk;
   logic       reset;
   logic [9:0] x;
   logic [9:0] y;
   logic [6:0] ascii;

   int n_checks = 0;
   int n_fail   = 0;

   text_screen_writer_if bus ();

   text_screen_writer dut (
      .i_clk       (clk),
      .i_reset     (reset),
      .cmd         (bus),
      .i_x         (x),
      .i_y         (y),
      .o_ascii_out (ascii)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic read_cell(input int row, input int col, output logic [6:0] val);
      x = 10'(col * 8);
      y = 10'(row * 16);
      @(posedge clk); #1;
      val = ascii;
   endtask

   // Issues one command; lat is cycles from acceptance to done (-1 on timeout).
   task automatic run_cmd(input logic [1:0] op, input logic [4:0] row, input logic [6:0] col,
                          input logic [6:0] ch, input logic [2:0] id,
                          output int lat, output logic err_o, output int rdy_hi);
      int guard = 0;
      while (!bus.cmd_ready && guard < 10) begin
         @(posedge clk); #1;
         guard++;
      end
      bus.cmd_op = op; bus.cmd_row = row; bus.cmd_col = col;
      bus.cmd_char = ch; bus.cmd_msg_id = id; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      check("busy_after_accept", 32'(bus.busy), 1);
      // Scramble fields; the block must use its latched copies.
      bus.cmd_op = 2'd1; bus.cmd_row = 5'd0; bus.cmd_col = 7'd0;
      bus.cmd_char = 7'h7f; bus.cmd_msg_id = 3'd7;
      lat = 1; rdy_hi = 0; err_o = 1'b0;
      while (!bus.done && lat < 3000) begin
         if (bus.cmd_ready) rdy_hi++;
         @(posedge clk); #1;
         lat++;
      end
      err_o = bus.err;
      if (!bus.done) lat = -1;
      bus.cmd_valid = 1'b0;
      @(posedge clk); #1;
      check("done_one_cycle", 32'(bus.done), 0);
   endtask

   logic [6:0] v;
   int         lat;
   logic       e;
   int         rdy;
   int         bad;
   logic       done_seen;
   logic [6:0] exp_win [8]    = '{7'h47, 7'h41, 7'h4D, 7'h45, 7'h20, 7'h57, 7'h49, 7'h4E};
   logic [6:0] exp_title [12] = '{7'h57, 7'h48, 7'h41, 7'h43, 7'h4B, 7'h20,
                                  7'h41, 7'h20, 7'h4D, 7'h4F, 7'h4C, 7'h45};

   initial begin
      reset = 1'b0;
      x = '0; y = '0;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_row = '0;
      bus.cmd_col = '0; bus.cmd_char = '0; bus.cmd_msg_id = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_err", 32'(bus.err), 0);
      check("rst_ready", 32'(bus.cmd_ready), 1);
      check("rst_ascii", 32'(ascii), 32'h20);
      reset = 1'b1;
      @(posedge clk); #1;

      // 1: clear
      run_cmd(2'd1, 5'd0, 7'd0, 7'h00, 3'd0, lat, e, rdy);
      check("clear_latency", 32'(lat), 2401);
      check("clear_err", 32'(e), 0);
      check("clear_ready_low", 32'(rdy), 0);
      bad = 0;
      for (int r = 0; r < 30; r++)
         for (int c = 0; c < 80; c++) begin
            read_cell(r, c, v);
            if (v !== 7'h20) bad++;
         end
      check("clear_sweep_bad", 32'(bad), 0);

      // 2: write char
      run_cmd(2'd0, 5'd15, 7'd32, 7'h47, 3'd0, lat, e, rdy);
      check("wchar_latency", 32'(lat), 2);
      check("wchar_err", 32'(e), 0);
      for (int xi = 256; xi < 264; xi++) begin
         x = 10'(xi); y = 10'd240;
         @(posedge clk); #1;
         check("wchar_read_y240", 32'(ascii), 32'h47);
         y = 10'd255;
         @(posedge clk); #1;
         check("wchar_read_y255", 32'(ascii), 32'h47);
      end
      x = 10'd264; y = 10'd240;
      @(posedge clk); #1;
      check("wchar_read_x264", 32'(ascii), 32'h20);

      // 3: message "GAME WIN"
      run_cmd(2'd2, 5'd15, 7'd32, 7'h00, 3'd1, lat, e, rdy);
      check("msg_win_latency", 32'(lat), 9);
      for (int i = 0; i < 8; i++) begin
         read_cell(15, 32 + i, v);
         check("msg_win_cell", 32'(v), 32'(exp_win[i]));
      end
      read_cell(15, 40, v);
      check("msg_win_after", 32'(v), 32'h20);

      // 4: title message wrapping bottom-right to top-left
      run_cmd(2'd2, 5'd29, 7'd75, 7'h00, 3'd0, lat, e, rdy);
      check("msg_title_latency", 32'(lat), 13);
      for (int i = 0; i < 5; i++) begin
         read_cell(29, 75 + i, v);
         check("msg_wrap_row29", 32'(v), 32'(exp_title[i]));
      end
      for (int i = 0; i < 7; i++) begin
         read_cell(0, i, v);
         check("msg_wrap_row0", 32'(v), 32'(exp_title[5 + i]));
      end
      read_cell(1, 0, v);
      check("msg_wrap_row1", 32'(v), 32'h20);

      // 5: range errors, empty message, nop
      run_cmd(2'd0, 5'd15, 7'd80, 7'h5A, 3'd0, lat, e, rdy);
      check("err_col_latency", 32'(lat), 1);
      check("err_col_err", 32'(e), 1);
      read_cell(16, 0, v);
      check("err_col_nowrite", 32'(v), 32'h20);
      run_cmd(2'd0, 5'd30, 7'd5, 7'h5A, 3'd0, lat, e, rdy);
      check("err_row_latency", 32'(lat), 1);
      check("err_row_err", 32'(e), 1);
      read_cell(0, 5, v);
      check("err_row_nowrite", 32'(v), 32'h4C);
      run_cmd(2'd2, 5'd15, 7'd32, 7'h00, 3'd5, lat, e, rdy);
      check("msg_empty_latency", 32'(lat), 1);
      check("msg_empty_err", 32'(e), 0);
      read_cell(15, 32, v);
      check("msg_empty_nowrite", 32'(v), 32'h47);
      run_cmd(2'd3, 5'd31, 7'd127, 7'h00, 3'd0, lat, e, rdy);
      check("nop_latency", 32'(lat), 1);
      check("nop_err", 32'(e), 0);

      // 6: reset 100 cycles into a clear; markers at cells 99 and 100
      run_cmd(2'd0, 5'd1, 7'd19, 7'h5A, 3'd0, lat, e, rdy);
      run_cmd(2'd0, 5'd1, 7'd20, 7'h5A, 3'd0, lat, e, rdy);
      x = 10'd256; y = 10'd240;
      bus.cmd_op = 2'd1; bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      done_seen = 1'b0;
      repeat (100) begin
         @(posedge clk); #1;
         if (bus.done) done_seen = 1'b1;
      end
      check("abort_pre_ascii", 32'(ascii), 32'h47);
      check("abort_pre_busy", 32'(bus.busy), 1);
      #1;
      reset = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_ready", 32'(bus.cmd_ready), 1);
      check("abort_err", 32'(bus.err), 0);
      check("abort_ascii", 32'(ascii), 32'h20);
      repeat (3) begin
         @(posedge clk); #1;
         if (bus.done) done_seen = 1'b1;
      end
      check("abort_no_done", 32'(done_seen), 0);
      reset = 1'b1;
      read_cell(0, 1, v);
      check("abort_cell1", 32'(v), 32'h20);
      read_cell(1, 19, v);
      check("abort_cell99", 32'(v), 32'h20);
      read_cell(1, 20, v);
      check("abort_cell100", 32'(v), 32'h5A);
      read_cell(15, 32, v);
      check("abort_cell_far", 32'(v), 32'h47);
      read_cell(29, 79, v);
      check("abort_cell_last", 32'(v), 32'h4B);
      x = 10'd700; y = 10'd240;
      @(posedge clk); #1;
      check("offscreen_x700", 32'(ascii), 32'h20);
      x = 10'd0; y = 10'd480;
      @(posedge clk); #1;
      check("offscreen_y480", 32'(ascii), 32'h20);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
